hbm_wt_scale_unpack: RTL and testbench
======================================

HBM_WT_SCALE_UNPACK -- requirements
Module: hbm_wt_scale_unpack

Interface
REQ-001 SHALL have parameter HBM_DW, default 256: HBM AXI read-data beat width in bits.
REQ-002 SHALL have parameter WT_DW, default 4: quantised weight width in bits.
REQ-003 SHALL have parameter SCALE_DW, default 16: FP quant-scale width in bits.
REQ-004 SHALL have parameter T_QUANT_BLOCK, default 128: number of CHin sharing one scale.
REQ-005 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, asynchronous active-low reset); one clock, reset asynchronous and active-low.
REQ-006 SHALL have start (input, 1): a one-cycle pulse that launches a job.
REQ-007 SHALL have cfg_chin (input, 16): padded CHin per output channel, a multiple of HBM_DW/WT_DW, nonzero.
REQ-008 SHALL have cfg_rows (input, 16): number of output-channel rows in the job, nonzero.
REQ-009 SHALL have s_vld (input, 1), s_rdy (output, 1) and s_dat (input, HBM_DW): the HBM read-beat stream.
REQ-010 SHALL have m_vld (output, 1), m_rdy (input, 1), m_wt (output, HBM_DW), m_scale (output, SCALE_DW) and m_last (output, 1; marks the last weight beat of a row): the stream to the MVM core.
REQ-011 SHALL have busy (output, 1) and done (output, 1; one-cycle pulse).

Function
REQ-012 SHALL use these derived constants: WPB = HBM_DW/WT_DW weights per beat; SPB = HBM_DW/SCALE_DW scales per beat; GROUP_CHIN = SPB*T_QUANT_BLOCK; GROUP_BEATS = GROUP_CHIN/WPB. With the defaults these are 64, 16, 2048 and 32.
REQ-013 SHALL assume this input row layout: for each group of GROUP_CHIN CHin, one scale beat followed by that group's weight beats. The last group holds rem = cfg_chin mod GROUP_CHIN CHin (a full group if rem = 0) and has ceil(rem/WPB) weight beats.
REQ-014 SHALL implement the FSM states IDLE, SCALE, WT:
  - IDLE to SCALE on start; cfg_chin and cfg_rows are latched at that point.
  - SCALE to WT on the handshake of the scale beat.
  - WT to SCALE after the group's last weight beat when the row has further groups, or when further rows remain.
  - WT to IDLE after the last beat of the last row.
REQ-015 In SCALE, SHALL assert s_rdy=1, capture s_dat into a scale register, and produce no output beat.
REQ-016 In WT, each accepted beat SHALL appear on m_wt with m_scale = scale slice [k*SCALE_DW +: SCALE_DW], where k = (beat index within group * WPB)/T_QUANT_BLOCK.
REQ-017 The output SHALL be one registered stage: latency 1 cycle from s handshake to m_vld, full throughput of 1 beat/cycle when m_rdy=1.
REQ-018 SHALL set s_rdy in WT to (!m_vld || m_rdy); m_vld, m_wt, m_scale and m_last SHALL hold stable while m_vld=1 and m_rdy=0.
REQ-019 SHALL assert m_last with the last weight beat of each row.
REQ-020 SHALL pulse done for one cycle when the final m_last beat is handshaked; busy SHALL be 1 from the cycle after start until done.
REQ-021 start while busy SHALL be ignored.
REQ-022 s_rdy SHALL be 0 in IDLE.
REQ-023 Group and row counters SHALL wrap to 0 at the row boundary, with no bubble between rows.

Reset
REQ-024 On rst_n=0, SHALL return to IDLE immediately from any state, including mid-row.
REQ-025 Reset values SHALL be: m_vld=0, s_rdy=0, m_last=0, busy=0, done=0, m_wt=0, m_scale=0; all counters and the scale register 0.

Structure
REQ-026 HBM_DW, WT_DW, SCALE_DW, T_QUANT_BLOCK, the derived constants of REQ-012 and the FSM state enum SHALL live in the shared HBM package.
REQ-027 The output register slice SHALL be one sub-module, hbm_pipe_reg (valid/ready register, data width parameterised); all else SHALL be inline.

Verification
REQ-028 cfg_chin=2048, cfg_rows=1, scale beat with slice j = j+1:
  - exactly 32 outputs;
  - beats 0,1 carry m_scale=1 and beats 30,31 carry m_scale=16;
  - m_last and done on beat 31.
REQ-029 cfg_chin=2176, cfg_rows=1:
  - 34 outputs;
  - beat 32 uses scale slice 0 of the second scale beat;
  - m_last on output 33.
REQ-030 cfg_chin=128, cfg_rows=3:
  - 6 outputs with m_last on outputs 1, 3 and 5;
  - 3 scale beats consumed;
  - done once.
REQ-031 m_rdy toggling pseudo-randomly at 50%: output sequence identical to the m_rdy=1 run; no beat dropped or duplicated; data held stable while stalled.
REQ-032 rst_n asserted at WT beat 10 of a 2048 job:
  - next cycle m_vld=0, busy=0;
  - a fresh start with cfg_chin=2048 reproduces the REQ-028 result.
REQ-033 start pulsed again at beat 5 while busy: ignored; output count unchanged.

Source files
------------

// File: rtl/hbm_wt_scale_unpack_pkg.sv
// Shared HBM constants and types for the weight/scale unpacker.
// Derived constants follow from the beat, weight and scale widths.
package hbm_wt_scale_unpack_pkg;

  localparam int HBM_DW        = 256;
  localparam int WT_DW         = 4;
  localparam int SCALE_DW      = 16;
  localparam int T_QUANT_BLOCK = 128;

  localparam int WPB         = HBM_DW / WT_DW;
  localparam int SPB         = HBM_DW / SCALE_DW;
  localparam int GROUP_CHIN  = SPB * T_QUANT_BLOCK;
  localparam int GROUP_BEATS = GROUP_CHIN / WPB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    WT    = 2'd2
  } state_t;

endpackage

// File: rtl/hbm_wt_scale_unpack_pipe_reg.sv
// Single valid/ready register stage with a parameterised payload.
// Accepts a new word whenever the stage is empty or is being drained.
module hbm_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [DW-1:0] o_dat
);

  logic          r_vld;
  logic [DW-1:0] r_dat;

  assign o_rdy = !r_vld || i_rdy;
  assign o_vld = r_vld;
  assign o_dat = r_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_vld && o_rdy) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/hbm_wt_scale_unpack.sv
// Splits an HBM row stream into per-group scale beats and weight beats,
// tagging each weight beat with its quant scale and row-end marker.
module hbm_wt_scale_unpack #(
  parameter int HBM_DW        = hbm_wt_scale_unpack_pkg::HBM_DW,
  parameter int WT_DW         = hbm_wt_scale_unpack_pkg::WT_DW,
  parameter int SCALE_DW      = hbm_wt_scale_unpack_pkg::SCALE_DW,
  parameter int T_QUANT_BLOCK = hbm_wt_scale_unpack_pkg::T_QUANT_BLOCK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         cfg_chin,
  input  logic [15:0]         cfg_rows,
  input  logic                s_vld,
  output logic                s_rdy,
  input  logic [HBM_DW-1:0]   s_dat,
  output logic                m_vld,
  input  logic                m_rdy,
  output logic [HBM_DW-1:0]   m_wt,
  output logic [SCALE_DW-1:0] m_scale,
  output logic                m_last,
  output logic                busy,
  output logic                done
);
  import hbm_wt_scale_unpack_pkg::*;

  localparam int M_WPB         = HBM_DW / WT_DW;
  localparam int M_SPB         = HBM_DW / SCALE_DW;
  localparam int M_GROUP_CHIN  = M_SPB * T_QUANT_BLOCK;
  localparam int M_GROUP_BEATS = M_GROUP_CHIN / M_WPB;
  localparam int PW            = HBM_DW + SCALE_DW + 1;

  state_t r_state, w_nextState;

  logic [HBM_DW-1:0]   r_scale;
  logic [15:0]         r_rows, r_ngrp, r_lastBeats;
  logic [15:0]         r_row, r_grp, r_beat;
  logic                r_busy, r_final;

  logic                w_start, w_sHs, w_pipeRdy, w_pipeInVld;
  logic                w_grpLast, w_rowLast, w_beatLast, w_done;
  logic [15:0]         w_ngrp, w_lastBeats, w_beatLimit;
  logic [31:0]         w_k;
  logic [SCALE_DW-1:0] w_scaleSel;
  logic [PW-1:0]       w_pipeIn, w_pipeOut;
  int                  w_chinI, w_remI;

  assign w_start = start && !r_busy && (r_state == IDLE);
  assign w_sHs   = s_vld && s_rdy;

  // Group count and size of the trailing (possibly partial) group.
  always_comb begin
    w_chinI     = int'(cfg_chin);
    w_remI      = w_chinI % M_GROUP_CHIN;
    w_ngrp      = 16'((w_chinI + M_GROUP_CHIN - 1) / M_GROUP_CHIN);
    w_lastBeats = (w_remI == 0) ? 16'(M_GROUP_BEATS)
                                : 16'((w_remI + M_WPB - 1) / M_WPB);
  end

  always_comb begin
    w_grpLast   = (r_grp == r_ngrp - 16'd1);
    w_rowLast   = (r_row == r_rows - 16'd1);
    w_beatLimit = w_grpLast ? r_lastBeats : 16'(M_GROUP_BEATS);
    w_beatLast  = (r_beat == w_beatLimit - 16'd1);
    w_k         = (32'(r_beat) * 32'(M_WPB)) / 32'(T_QUANT_BLOCK);
    w_scaleSel  = r_scale[w_k*SCALE_DW +: SCALE_DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (w_start) w_nextState = SCALE;
      SCALE: if (w_sHs) w_nextState = WT;
      WT: begin
        if (w_sHs && w_beatLast) begin
          if (w_grpLast && w_rowLast) w_nextState = IDLE;
          else                        w_nextState = SCALE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    s_rdy       = 1'b0;
    w_pipeInVld = 1'b0;
    case (r_state)
      SCALE: s_rdy = 1'b1;
      WT: begin
        s_rdy       = w_pipeRdy;
        w_pipeInVld = s_vld;
      end
      default: s_rdy = 1'b0;
    endcase
  end

  // Counters advance only on accepted weight beats; every row restarts with a scale beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows      <= '0;
      r_ngrp      <= '0;
      r_lastBeats <= '0;
      r_row       <= '0;
      r_grp       <= '0;
      r_beat      <= '0;
      r_scale     <= '0;
    end else begin
      if (w_start) begin
        r_rows      <= cfg_rows;
        r_ngrp      <= w_ngrp;
        r_lastBeats <= w_lastBeats;
        r_row       <= '0;
        r_grp       <= '0;
        r_beat      <= '0;
      end
      if (r_state == SCALE && w_sHs) r_scale <= s_dat;
      if (r_state == WT && w_sHs) begin
        if (w_beatLast) begin
          r_beat <= '0;
          if (w_grpLast) begin
            r_grp <= '0;
            r_row <= w_rowLast ? 16'd0 : r_row + 16'd1;
          end else begin
            r_grp <= r_grp + 16'd1;
          end
        end else begin
          r_beat <= r_beat + 16'd1;
        end
      end
    end
  end

  // The job stays busy until the final beat leaves the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_final <= 1'b0;
    end else begin
      if (w_start)     r_busy <= 1'b1;
      else if (w_done) r_busy <= 1'b0;
      if (r_state == WT && w_sHs && w_beatLast && w_grpLast && w_rowLast)
        r_final <= 1'b1;
      else if (w_done)
        r_final <= 1'b0;
    end
  end

  assign w_pipeIn = {w_grpLast && w_beatLast, w_scaleSel, s_dat};

  hbm_pipe_reg #(
    .DW(PW)
  ) u_outReg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (w_pipeInVld),
    .o_rdy (w_pipeRdy),
    .i_dat (w_pipeIn),
    .o_vld (m_vld),
    .i_rdy (m_rdy),
    .o_dat (w_pipeOut)
  );

  assign m_last  = w_pipeOut[PW-1];
  assign m_scale = w_pipeOut[HBM_DW +: SCALE_DW];
  assign m_wt    = w_pipeOut[HBM_DW-1:0];
  assign w_done  = m_vld && m_rdy && m_last && r_final;
  assign done    = w_done;
  assign busy    = r_busy;

endmodule

// File: tb/tb_hbm_wt_scale_unpack.sv
// Scoreboard bench for hbm_wt_scale_unpack: expected beats are queued as
// the stimulus is sent and compared as the unpacker emits them.
module tb_hbm_wt_scale_unpack;

  localparam int EW = 274;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  cfg_chin = '0;
  logic [15:0]  cfg_rows = '0;
  logic         s_vld = 1'b0;
  logic         s_rdy;
  logic [255:0] s_dat = '0;
  logic         m_vld;
  logic         m_rdy = 1'b1;
  logic [255:0] m_wt;
  logic [15:0]  m_scale;
  logic         m_last;
  logic         busy;
  logic         done;

  int           testsRun = 0;
  int           testsFailed = 0;
  int           jobOut = 0;
  int           jobDone = 0;
  bit           rdyRandom = 1'b0;
  bit           prevStall = 1'b0;
  logic [EW-1:0] sb[$];
  logic [15:0]  obsScale[64];
  logic         obsLast[64];

  hbm_wt_scale_unpack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_chin (cfg_chin),
    .cfg_rows (cfg_rows),
    .s_vld    (s_vld),
    .s_rdy    (s_rdy),
    .s_dat    (s_dat),
    .m_vld    (m_vld),
    .m_rdy    (m_rdy),
    .m_wt     (m_wt),
    .m_scale  (m_scale),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_rdy = rdyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: pops one expectation per handshaked beat.
  always @(negedge clk) begin
    logic [EW-1:0] exp;
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) checkOutput("hold_vld", EW'(m_vld), EW'(1));
      if (m_vld && m_rdy) begin
        if (jobOut < 64) begin
          obsScale[jobOut] = m_scale;
          obsLast[jobOut]  = m_last;
        end
        jobOut++;
        if (sb.size() == 0) begin
          checkOutput("extra_beat", EW'(1), EW'(0));
        end else begin
          exp = sb.pop_front();
          checkOutput("beat", {done, m_last, m_scale, m_wt}, exp);
        end
      end
      if (done) jobDone++;
      prevStall = m_vld && !m_rdy;
    end
  end

  function automatic logic [15:0] scaleVal(input int r, input int g, input int k);
    return 16'(k + 1 + g * 16 + r * 256);
  endfunction

  task automatic sendBeat(input logic [255:0] d, output bit ok);
    ok = 1'b0;
    s_vld = 1'b1;
    s_dat = d;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (s_rdy) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("s_rdy_timeout", EW'(0), EW'(1));
  endtask

  task automatic applyStimulus(input int chin, input int rows, input int abortAt, input int dupAt);
    int ngrp, rem, lastBeats, nb, wIdx, expCount;
    logic [255:0] d;
    logic [EW-1:0] exp;
    bit ok, lastB;
    ngrp      = (chin + 2047) / 2048;
    rem       = chin % 2048;
    lastBeats = (rem == 0) ? 32 : (rem + 63) / 64;
    expCount  = rows * ((ngrp - 1) * 32 + lastBeats);
    jobOut = 0;
    jobDone = 0;
    sb.delete();
    wIdx = 0;
    @(posedge clk);
    #1;
    cfg_chin = 16'(chin);
    cfg_rows = 16'(rows);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int r = 0; r < rows; r++) begin
      for (int g = 0; g < ngrp; g++) begin
        for (int j = 0; j < 16; j++) d[j*16 +: 16] = scaleVal(r, g, j);
        sendBeat(d, ok);
        if (!ok) begin s_vld = 1'b0; return; end
        nb = (g == ngrp - 1) ? lastBeats : 32;
        for (int b = 0; b < nb; b++) begin
          if (wIdx == abortAt) begin
            s_vld = 1'b0;
            rst_n = 1'b0;
            sb.delete();
            @(negedge clk);
            checkOutput("abort_m_vld", EW'(m_vld), EW'(0));
            checkOutput("abort_busy", EW'(busy), EW'(0));
            checkOutput("abort_s_rdy", EW'(s_rdy), EW'(0));
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
          end
          for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
          lastB = (g == ngrp - 1) && (b == nb - 1);
          exp = {lastB && (r == rows - 1), lastB, scaleVal(r, g, (b * 64) / 128), d};
          sb.push_back(exp);
          if (wIdx == dupAt) start = 1'b1;
          sendBeat(d, ok);
          start = 1'b0;
          if (!ok) begin s_vld = 1'b0; return; end
          wIdx++;
        end
      end
    end
    s_vld = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (jobDone > 0) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("done_timeout", EW'(0), EW'(1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("out_count", EW'(jobOut), EW'(expCount));
    checkOutput("done_count", EW'(jobDone), EW'(1));
    checkOutput("sb_empty", EW'(sb.size()), EW'(0));
    checkOutput("busy_end", EW'(busy), EW'(0));
    checkOutput("s_rdy_idle", EW'(s_rdy), EW'(0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_vld", EW'(m_vld), EW'(0));
    checkOutput("rst_s_rdy", EW'(s_rdy), EW'(0));
    checkOutput("rst_busy", EW'(busy), EW'(0));
    checkOutput("rst_done", EW'(done), EW'(0));
    checkOutput("rst_m_last", EW'(m_last), EW'(0));
    checkOutput("rst_m_wt", EW'(m_wt), EW'(0));
    checkOutput("rst_m_scale", EW'(m_scale), EW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single full group, m_rdy high");
    applyStimulus(2048, 1, -1, -1);
    checkOutput("g1_b0_scale", EW'(obsScale[0]), EW'(1));
    checkOutput("g1_b1_scale", EW'(obsScale[1]), EW'(1));
    checkOutput("g1_b30_scale", EW'(obsScale[30]), EW'(16));
    checkOutput("g1_b31_scale", EW'(obsScale[31]), EW'(16));
    checkOutput("g1_b30_last", EW'(obsLast[30]), EW'(0));
    checkOutput("g1_b31_last", EW'(obsLast[31]), EW'(1));

    $display("[TB] partial second group");
    applyStimulus(2176, 1, -1, -1);
    checkOutput("g2_b31_last", EW'(obsLast[31]), EW'(0));
    checkOutput("g2_b32_scale", EW'(obsScale[32]), EW'(17));
    checkOutput("g2_b33_last", EW'(obsLast[33]), EW'(1));

    $display("[TB] three short rows");
    applyStimulus(128, 3, -1, -1);
    checkOutput("r3_b0_last", EW'(obsLast[0]), EW'(0));
    checkOutput("r3_b1_last", EW'(obsLast[1]), EW'(1));
    checkOutput("r3_b3_last", EW'(obsLast[3]), EW'(1));
    checkOutput("r3_b5_last", EW'(obsLast[5]), EW'(1));
    checkOutput("r3_b2_scale", EW'(obsScale[2]), EW'(257));

    $display("[TB] random backpressure");
    rdyRandom = 1'b1;
    applyStimulus(2048, 1, -1, -1);
    applyStimulus(2176, 2, -1, -1);
    rdyRandom = 1'b0;

    $display("[TB] reset mid-row then restart");
    applyStimulus(2048, 1, 10, -1);
    applyStimulus(2048, 1, -1, -1);
    checkOutput("rs_b0_scale", EW'(obsScale[0]), EW'(1));
    checkOutput("rs_b31_scale", EW'(obsScale[31]), EW'(16));
    checkOutput("rs_b31_last", EW'(obsLast[31]), EW'(1));

    $display("[TB] start pulsed while busy");
    applyStimulus(2048, 1, -1, 5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
